// File: rtl/test_status_dev_pkg.sv
// -----------------------------------------------------------------------------
// test_status_dev_pkg
// Shared definitions for the test-status responder: register offsets,
// RESULT bit positions, one-hot state encoding and the default watchdog limit.
// Optional feature macro used by the design: TEST_STATUS_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package test_status_dev_pkg;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] OFF_RESULT  = 2'd0;
  localparam logic [1:0] OFF_TESTNUM = 2'd1;
  localparam logic [1:0] OFF_CYCLES  = 2'd2;
  localparam logic [1:0] OFF_LIMIT   = 2'd3;

  // RESULT write: bit 0 carries the verdict
  localparam int RES_PASS_BIT = 0;

  // RESULT read layout: {28'b0, timeout, pass, done, run}
  localparam int STAT_RUN_BIT     = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_PASS_BIT    = 2;
  localparam int STAT_TIMEOUT_BIT = 3;

  // 5 ms at 50 MHz
  localparam logic [31:0] TIMEOUT_DEFAULT_VAL = 32'd250000;

  typedef enum logic [3:0] {
    ST_RUN     = 4'b0001,
    ST_PASS    = 4'b0010,
    ST_FAIL    = 4'b0100,
    ST_TIMEOUT = 4'b1000
  } state_e;

  // Build the RESULT read word from the current state
  function automatic logic [31:0] pack_result(input state_e st);
    logic [31:0] word;
    word = 32'd0;
    word[STAT_RUN_BIT]     = (st == ST_RUN);
    word[STAT_DONE_BIT]    = (st == ST_PASS) || (st == ST_FAIL) || (st == ST_TIMEOUT);
    word[STAT_PASS_BIT]    = (st == ST_PASS);
    word[STAT_TIMEOUT_BIT] = (st == ST_TIMEOUT);
    return word;
  endfunction

endpackage

// File: rtl/test_status_dev_if.sv
// -----------------------------------------------------------------------------
// test_status_dev_if
// Simple request/acknowledge register bus used by the test-status responder.
//   req_i  : one access per cycle while high
//   we_i   : 1 = write, 0 = read
//   addr_i : byte address (responder decodes [3:2])
//   data_i : write data
//   data_o : read data, non-zero only alongside ack_o
//   ack_o  : one-cycle acknowledge, one cycle after each request
// Modports: master (bus initiator), slave (responder).
// -----------------------------------------------------------------------------
interface test_status_dev_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output req_i, we_i, addr_i, data_i,
    input  data_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, data_i,
    output data_o, ack_o
  );
endinterface

// File: rtl/test_status_dev_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter with enable and synchronous clear that holds at all-ones
// instead of wrapping.
//   clk   : clock, rising edge
//   clr   : synchronous clear (highest priority)
//   en    : count enable
//   count : current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: clear, saturating increment, or hold
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (en && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/test_status_dev.sv
// -----------------------------------------------------------------------------
// test_status_dev
// Memory-mapped test-status responder. The core writes its test number and a
// pass/fail verdict; the final result is held in registered status outputs.
// A cycle counter runs from reset release until a verdict is recorded. With
// TEST_STATUS_TIMEOUT_EN defined, a programmable watchdog declares a timeout
// when the cycle count reaches the limit before a verdict arrives.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : register bus (slave modport)
//   done_o     : verdict or timeout recorded
//   pass_o     : verdict was pass
//   timeout_o  : watchdog expired
//   testnum_o  : last accepted TESTNUM value
// Parameters:
//   TIMEOUT_DEFAULT : reset value of the watchdog limit in cycles
// -----------------------------------------------------------------------------
module test_status_dev
  import test_status_dev_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_DEFAULT = TIMEOUT_DEFAULT_VAL
) (
  input  logic                    clk,
  input  logic                    rst,
  test_status_dev_if.slave        bus,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    timeout_o,
  output logic [31:0]             testnum_o
);

  state_e      state_r;
  state_e      next_s;
  logic [31:0] cycles_s;
  logic [31:0] testnum_r;
  logic [31:0] data_r;
  logic        ack_r;
  logic        done_r;
  logic        pass_r;
  logic        timeout_r;
  logic [31:0] rdata_s;
  logic [1:0]  off_s;
  logic        wr_s;
  logic        rd_s;
  logic        result_wr_s;
  logic        wd_fire_s;
  logic        cnt_en_s;

  // Address bits outside [3:2] are decoded by the interconnect
  logic        unused_addr_s;
  assign unused_addr_s = &{1'b0, bus.addr_i[31:4], bus.addr_i[1:0]};

  assign off_s       = bus.addr_i[3:2];
  assign wr_s        = bus.req_i & bus.we_i;
  assign rd_s        = bus.req_i & ~bus.we_i;
  assign result_wr_s = wr_s & (off_s == OFF_RESULT);

`ifdef TEST_STATUS_TIMEOUT_EN
  logic [31:0] limit_r;

  // Watchdog limit register, writable in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      limit_r <= TIMEOUT_DEFAULT;
    end else if (wr_s && (off_s == OFF_LIMIT)) begin
      limit_r <= bus.data_i;
    end else begin
      limit_r <= limit_r;
    end
  end

  // >= rather than == so a limit written below the current count still fires
  assign wd_fire_s = (cycles_s >= limit_r);
`else
  logic [31:0] unused_limit_s;
  assign unused_limit_s = TIMEOUT_DEFAULT;
  assign wd_fire_s      = 1'b0;
`endif

  // Next-state logic; a verdict write has priority over the watchdog
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (result_wr_s) begin
          next_s = bus.data_i[RES_PASS_BIT] ? ST_PASS : ST_FAIL;
        end else if (wd_fire_s) begin
          next_s = ST_TIMEOUT;
        end else begin
          next_s = ST_RUN;
        end
      end
      ST_PASS:    next_s = ST_PASS;
      ST_FAIL:    next_s = ST_FAIL;
      ST_TIMEOUT: next_s = ST_TIMEOUT;
      default:    next_s = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_s;
    end
  end

  // Status outputs registered from the next state so they move on the
  // same edge that records the verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      done_r    <= (next_s != ST_RUN);
      pass_r    <= (next_s == ST_PASS);
      timeout_r <= (next_s == ST_TIMEOUT);
    end
  end

  // Count only while staying in RUN, so the terminal edge freezes CYCLES
  assign cnt_en_s = (state_r == ST_RUN) && (next_s == ST_RUN);

  sat_counter #(.WIDTH(32)) u_cycles (
    .clk   (clk),
    .clr   (rst),
    .en    (cnt_en_s),
    .count (cycles_s)
  );

  // TESTNUM register; frozen once a result is recorded
  always_ff @(posedge clk) begin
    if (rst) begin
      testnum_r <= 32'd0;
    end else if (wr_s && (off_s == OFF_TESTNUM) && (state_r == ST_RUN)) begin
      testnum_r <= bus.data_i;
    end else begin
      testnum_r <= testnum_r;
    end
  end

  // Read multiplexer over pre-update register contents
  always_comb begin
    rdata_s = 32'd0;
    case (off_s)
      OFF_RESULT:  rdata_s = pack_result(state_r);
      OFF_TESTNUM: rdata_s = testnum_r;
      OFF_CYCLES:  rdata_s = cycles_s;
`ifdef TEST_STATUS_TIMEOUT_EN
      OFF_LIMIT:   rdata_s = limit_r;
`else
      OFF_LIMIT:   rdata_s = 32'd0;
`endif
      default:     rdata_s = 32'd0;
    endcase
  end

  // Bus response: ack every request one cycle later, data only for reads
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r  <= 1'b0;
      data_r <= 32'd0;
    end else begin
      ack_r  <= bus.req_i;
      data_r <= rd_s ? rdata_s : 32'd0;
    end
  end

  assign bus.ack_o  = ack_r;
  assign bus.data_o = data_r;
  assign done_o     = done_r;
  assign pass_o     = pass_r;
  assign timeout_o  = timeout_r;
  assign testnum_o  = testnum_r;

endmodule
